sha512_arbiter: RTL and testbench
=================================

Name: sha512_arbiter

Overview:
- Shares one SHA-512 core between NUM_REQ requesters, e.g. several CCI-P read streams or host-submitted jobs.
- Arbitration is per message and round-robin. The owner keeps the core from its first block until its last-block digest returns.
- Feeds 512-bit blocks to the core one at a time and waits for each digest.
- Intermediate digests are discarded; only the final digest is routed back to the owning requester.
- Sits between the request logic and the sha512 core, inside the AFU clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of grant id

Ports:
clk  in  1  AFU clock (pClk domain)
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a block on req_block[i]
req_block  in  NUM_REQ*512  block data; slice i = bits [512*i +: 512]
req_last  in  NUM_REQ  block is the last block of its message
req_ready  out  NUM_REQ  block accepted this cycle (combinational, owner only)
rsp_valid  out  NUM_REQ  one-cycle pulse: final digest for requester i
rsp_digest  out  512  final digest, shared bus, valid with rsp_valid
sha_block  out  512  block to core (registered)
sha_block_valid  out  1  one-cycle pulse to core
sha_first  out  1  high with sha_block_valid on the first block of a message
sha_ready  in  1  core can accept a block
sha_digest  in  512  core digest
sha_digest_valid  in  1  core digest strobe
busy  out  1  a message is in flight (state != IDLE)
grant_id  out  ID_W  current/last owner

Behaviour:
- Reset values:
  - All outputs are 0.
  - State = IDLE; rr_ptr = 0; first_flag = 1.
  - Reset mid-message abandons the message. No rsp_valid is produced.
- IDLE:
  - Scan req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - On the first hit i: grant_id <= i, first_flag <= 1, go to ISSUE next cycle.
  - No request: stay in IDLE.
  - req_ready is 0 for all requesters in IDLE.
- ISSUE:
  - req_ready[grant_id] = req_valid[grant_id] & sha_ready. All other req_ready bits are 0.
  - On accept:
    - sha_block <= req_block[grant_id]; sha_block_valid <= 1 for exactly one cycle.
    - sha_first <= first_flag; first_flag <= 0.
    - last_q <= req_last[grant_id]; go to WAIT.
  - If the owner deasserts req_valid, the arbiter stays in ISSUE indefinitely. Messages are atomic; there is no preemption.
- WAIT:
  - Hold until sha_digest_valid.
  - Then if last_q = 1:
    - rsp_digest <= sha_digest.
    - rsp_valid[grant_id] <= 1 for one cycle.
    - rr_ptr <= (grant_id+1) mod NUM_REQ.
    - Go to IDLE.
  - Else go to ISSUE; the intermediate digest is dropped.
- sha_digest_valid outside WAIT is ignored.
- Latency per block: accept in cycle t, sha_block_valid at t+1. After digest_valid in cycle d, the next accept can occur at the earliest in d+1.
- Final response: rsp_valid is asserted in the cycle after the last sha_digest_valid.
- The earliest new grant occurs in the cycle after rsp_valid (IDLE evaluation).
- Fairness: after requester i finishes, requester i+1 has the highest priority. Wrap-around: NUM_REQ-1 -> 0.
- Single-block message: req_last=1 on the first block, so sha_first=1 and a response follows that block's digest.
- rsp_valid is one-hot or all-zero.

Optional Feature:
- Macro: SHA512_ARB_STATS_EN.
- Defined:
  - Extra output msg_count (NUM_REQ*32): per-requester completed-message counters, incremented with rsp_valid.
  - Extra output blk_count (32): total blocks issued, incremented with sha_block_valid.
  - Counters wrap at 2^32 and are cleared by reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Single requester, NUM_REQ=4: req 2 sends 3 blocks (A,B,C; last on C), core digests D1,D2,D3.
   -> sha_first=1 only on A.
   -> Exactly one rsp_valid=4'b0100 with rsp_digest=D3.
   -> rr_ptr=3.
2. All four requesters valid from reset, each a 1-block message.
   -> Grants in order 0,1,2,3.
   -> Then requester 0 again if still valid; rsp_valid pulses 0001,0010,0100,1000.
3. Owner 1 drops req_valid mid-message for 10 cycles while requester 3 is valid.
   -> No grant to 3 and req_ready[3]=0.
   -> Message 1 completes after valid resumes.
4. sha_ready=0 for 5 cycles in ISSUE with the owner valid.
   -> req_ready=0 and no sha_block_valid; accept occurs in the first cycle with sha_ready=1.
5. Stray sha_digest_valid in IDLE, then reset asserted during WAIT.
   -> No rsp_valid; all outputs are 0 the cycle after reset, state IDLE, rr_ptr=0.
6. With SHA512_ARB_STATS_EN: two 2-block messages from requester 0.
   -> msg_count[0]=2, blk_count=4.

Source files
------------

// File: rtl/sha512_arbiter_if.sv
// Requester/core bus of the SHA-512 arbiter. slave = arbiter side, master = environment side.
// Stats ports exist only when SHA512_ARB_STATS_EN is defined.
interface sha512_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*512-1:0] req_block;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [511:0]           rsp_digest;
  logic [511:0]           sha_block;
  logic                   sha_block_valid;
  logic                   sha_first;
  logic                   sha_ready;
  logic [511:0]           sha_digest;
  logic                   sha_digest_valid;
  logic                   busy;
  logic [ID_W-1:0]        grant_id;
`ifdef SHA512_ARB_STATS_EN
  logic [NUM_REQ*32-1:0]  msg_count;
  logic [31:0]            blk_count;
`endif

  modport slave (
    input  req_valid, req_block, req_last, sha_ready, sha_digest, sha_digest_valid,
    output req_ready, rsp_valid, rsp_digest, sha_block, sha_block_valid, sha_first, busy,
`ifdef SHA512_ARB_STATS_EN
    output msg_count, blk_count,
`endif
    output grant_id
  );

  modport master (
    output req_valid, req_block, req_last, sha_ready, sha_digest, sha_digest_valid,
    input  req_ready, rsp_valid, rsp_digest, sha_block, sha_block_valid, sha_first, busy,
`ifdef SHA512_ARB_STATS_EN
    input  msg_count, blk_count,
`endif
    input  grant_id
  );
endinterface

// File: rtl/sha512_arbiter.sv
// Per-message round-robin arbiter sharing one SHA-512 core between NUM_REQ requesters.
// Define SHA512_ARB_STATS_EN to add msg_count/blk_count statistics outputs.
module sha512_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  sha512_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [ID_W:0]   NumReqW = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LastId  = ID_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                first_flag_q, first_flag_d;
  logic                last_q, last_d;
  logic [511:0]        sha_block_q, sha_block_d;
  logic                sha_block_valid_q, sha_block_valid_d;
  logic                sha_first_q, sha_first_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [511:0]        rsp_digest_q, rsp_digest_d;
  logic [NUM_REQ-1:0]  req_ready;
  logic                accept;
  logic                found;
  logic [ID_W-1:0]     pick;
  logic [ID_W:0]       scan_idx;

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= NumReqW) scan_idx = scan_idx - NumReqW;
      if (!found && bus.req_valid[scan_idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[ID_W-1:0];
      end
    end
  end

  assign accept = (state_q == StIssue) && bus.req_valid[grant_id_q] && bus.sha_ready;

  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    grant_id_d        = grant_id_q;
    first_flag_d      = first_flag_q;
    last_d            = last_q;
    sha_block_d       = sha_block_q;
    sha_block_valid_d = 1'b0;
    sha_first_d       = 1'b0;
    rsp_valid_d       = '0;
    rsp_digest_d      = rsp_digest_q;
    req_ready         = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_id_d   = pick;
          first_flag_d = 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        req_ready[grant_id_q] = accept;
        if (accept) begin
          sha_block_d       = bus.req_block[512*grant_id_q +: 512];
          sha_block_valid_d = 1'b1;
          sha_first_d       = first_flag_q;
          first_flag_d      = 1'b0;
          last_d            = bus.req_last[grant_id_q];
          state_d           = StWait;
        end
      end
      StWait: begin
        if (bus.sha_digest_valid) begin
          if (last_q) begin
            rsp_digest_d             = bus.sha_digest;
            rsp_valid_d[grant_id_q]  = 1'b1;
            rr_ptr_d                 = (grant_id_q == LastId) ? '0 : grant_id_q + 1'b1;
            state_d                  = StIdle;
          end else begin
            // Intermediate digest: dropped, core keeps chaining state itself.
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StIdle;
      rr_ptr_q          <= '0;
      grant_id_q        <= '0;
      first_flag_q      <= 1'b1;
      last_q            <= 1'b0;
      sha_block_q       <= '0;
      sha_block_valid_q <= 1'b0;
      sha_first_q       <= 1'b0;
      rsp_valid_q       <= '0;
      rsp_digest_q      <= '0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      grant_id_q        <= grant_id_d;
      first_flag_q      <= first_flag_d;
      last_q            <= last_d;
      sha_block_q       <= sha_block_d;
      sha_block_valid_q <= sha_block_valid_d;
      sha_first_q       <= sha_first_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_digest_q      <= rsp_digest_d;
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_digest      = rsp_digest_q;
  assign bus.sha_block       = sha_block_q;
  assign bus.sha_block_valid = sha_block_valid_q;
  assign bus.sha_first       = sha_first_q;
  assign bus.busy            = (state_q != StIdle);
  assign bus.grant_id        = grant_id_q;

`ifdef SHA512_ARB_STATS_EN
  logic [31:0] msg_cnt_q [NUM_REQ];
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) msg_cnt_q[i] <= '0;
      blk_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid_d[i]) msg_cnt_q[i] <= msg_cnt_q[i] + 32'd1;
      end
      if (sha_block_valid_d) blk_cnt_q <= blk_cnt_q + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_msg_cnt
    assign bus.msg_count[32*g +: 32] = msg_cnt_q[g];
  end
  assign bus.blk_count = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha512_arbiter.sv
// Directed bench for sha512_arbiter (NUM_REQ=4); the core is driven by hand from the stimulus.
// Stats checks compile in only with SHA512_ARB_STATS_EN.
module tb_sha512_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  logic [511:0] blk_pat [4];

  always #5 clk = ~clk;

  sha512_arbiter_if #(.NUM_REQ(4)) bus ();

  sha512_arbiter #(.NUM_REQ(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [511:0] pat(input logic [31:0] w);
    return {16{w}};
  endfunction

  function automatic logic [3:0] onehot(input int i);
    return 4'(1 << i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 512'(bus.req_ready), 512'd0);
    check({tag, "_rsp_valid"}, 512'(bus.rsp_valid), 512'd0);
    check({tag, "_rsp_digest"}, bus.rsp_digest, 512'd0);
    check({tag, "_sha_block"}, bus.sha_block, 512'd0);
    check({tag, "_sha_block_valid"}, 512'(bus.sha_block_valid), 512'd0);
    check({tag, "_sha_first"}, 512'(bus.sha_first), 512'd0);
    check({tag, "_busy"}, 512'(bus.busy), 512'd0);
    check({tag, "_grant_id"}, 512'(bus.grant_id), 512'd0);
  endtask

  // One single-block message; entered with the arbiter in IDLE, leaves it in IDLE.
  task automatic run_single(input int exp_id, input logic [511:0] dig);
    tick();
    check("rr_grant", 512'(bus.grant_id), 512'(exp_id));
    check("rr_ready", 512'(bus.req_ready), 512'(onehot(exp_id)));
    tick();
    check("rr_blk_valid", 512'(bus.sha_block_valid), 512'd1);
    check("rr_first", 512'(bus.sha_first), 512'd1);
    check("rr_blk", bus.sha_block, blk_pat[exp_id]);
    bus.sha_digest       = dig;
    bus.sha_digest_valid = 1'b1;
    tick();
    bus.sha_digest_valid = 1'b0;
    check("rr_rsp_valid", 512'(bus.rsp_valid), 512'(onehot(exp_id)));
    check("rr_rsp_digest", bus.rsp_digest, dig);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

`ifdef SHA512_ARB_STATS_EN
  task automatic two_block_msg();
    bus.req_last = 4'b0000;
    tick();
    tick();
    bus.sha_digest_valid = 1'b1;
    tick();
    bus.sha_digest_valid = 1'b0;
    bus.req_last = 4'b0001;
    tick();
    bus.sha_digest_valid = 1'b1;
    tick();
    bus.sha_digest_valid = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) blk_pat[i] = pat(32'hB000_0000 | 32'(i));
    reset                = 1'b1;
    bus.req_valid        = '0;
    bus.req_last         = '0;
    bus.req_block        = '0;
    bus.sha_ready        = 1'b1;
    bus.sha_digest       = '0;
    bus.sha_digest_valid = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Single requester 2, three blocks A,B,C.
    bus.req_valid = 4'b0100;
    bus.req_block[1024 +: 512] = pat(32'hAAAA_0001);
    tick();
    check("t1_grant", 512'(bus.grant_id), 512'd2);
    check("t1_busy", 512'(bus.busy), 512'd1);
    check("t1_ready_a", 512'(bus.req_ready), 512'h4);
    tick();
    check("t1_valid_a", 512'(bus.sha_block_valid), 512'd1);
    check("t1_first_a", 512'(bus.sha_first), 512'd1);
    check("t1_blk_a", bus.sha_block, pat(32'hAAAA_0001));
    check("t1_ready_wait", 512'(bus.req_ready), 512'd0);
    bus.req_block[1024 +: 512] = pat(32'hBBBB_0002);
    tick();
    check("t1_pulse_end", 512'(bus.sha_block_valid), 512'd0);
    bus.sha_digest = pat(32'hD1D1_D1D1);
    bus.sha_digest_valid = 1'b1;
    tick();
    bus.sha_digest_valid = 1'b0;
    check("t1_no_rsp_d1", 512'(bus.rsp_valid), 512'd0);
    check("t1_ready_b", 512'(bus.req_ready), 512'h4);
    tick();
    check("t1_valid_b", 512'(bus.sha_block_valid), 512'd1);
    check("t1_first_b", 512'(bus.sha_first), 512'd0);
    check("t1_blk_b", bus.sha_block, pat(32'hBBBB_0002));
    bus.req_block[1024 +: 512] = pat(32'hCCCC_0003);
    bus.req_last = 4'b0100;
    tick();
    bus.sha_digest = pat(32'hD2D2_D2D2);
    bus.sha_digest_valid = 1'b1;
    tick();
    bus.sha_digest_valid = 1'b0;
    check("t1_no_rsp_d2", 512'(bus.rsp_valid), 512'd0);
    tick();
    check("t1_first_c", 512'(bus.sha_first), 512'd0);
    check("t1_blk_c", bus.sha_block, pat(32'hCCCC_0003));
    bus.req_valid = 4'b0000;
    bus.sha_digest = pat(32'hD3D3_D3D3);
    bus.sha_digest_valid = 1'b1;
    tick();
    bus.sha_digest_valid = 1'b0;
    check("t1_rsp_valid", 512'(bus.rsp_valid), 512'h4);
    check("t1_rsp_digest", bus.rsp_digest, pat(32'hD3D3_D3D3));
    check("t1_idle", 512'(bus.busy), 512'd0);
    tick();
    check("t1_rsp_pulse", 512'(bus.rsp_valid), 512'd0);

    // rr_ptr is now 3: with everyone requesting, 3 wins, then 0.
    for (int i = 0; i < 4; i++) bus.req_block[512*i +: 512] = blk_pat[i];
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    run_single(3, pat(32'hE300_0000));
    run_single(0, pat(32'hE000_0000));

    // From reset all four valid: order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 5; i++) run_single(i % 4, pat(32'hF000_0000 | 32'(i)));

    // Owner 1 stalls for 10 cycles while requester 3 waits.
    bus.req_valid = 4'b0000;
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_last  = 4'b0000;
    tick();
    check("t3_grant1", 512'(bus.grant_id), 512'd1);
    tick();
    check("t3_valid_1a", 512'(bus.sha_block_valid), 512'd1);
    bus.req_valid = 4'b1000;
    bus.sha_digest_valid = 1'b1;
    tick();
    bus.sha_digest_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t3_stall_ready", 512'(bus.req_ready), 512'd0);
      check("t3_stall_grant", 512'(bus.grant_id), 512'd1);
      check("t3_stall_blk", 512'(bus.sha_block_valid), 512'd0);
      tick();
    end
    bus.req_valid = 4'b1010;
    bus.req_last  = 4'b0010;
    #1;
    check("t3_resume_ready", 512'(bus.req_ready), 512'h2);
    tick();
    check("t3_valid_1b", 512'(bus.sha_block_valid), 512'd1);
    bus.req_valid = 4'b1000;
    bus.req_last  = 4'b0000;
    bus.sha_digest = pat(32'h1111_2222);
    bus.sha_digest_valid = 1'b1;
    tick();
    bus.sha_digest_valid = 1'b0;
    check("t3_rsp_valid", 512'(bus.rsp_valid), 512'h2);
    check("t3_rsp_digest", bus.rsp_digest, pat(32'h1111_2222));
    tick();
    check("t3_grant3", 512'(bus.grant_id), 512'd3);
    tick();
    check("t3_valid_3", 512'(bus.sha_block_valid), 512'd1);

    // Reset during WAIT, then a stray digest in IDLE.
    reset = 1'b1;
    bus.req_valid = 4'b0000;
    tick();
    check_all_zero("t5");
    reset = 1'b0;
    bus.sha_digest = pat(32'h5555_AAAA);
    bus.sha_digest_valid = 1'b1;
    tick();
    bus.sha_digest_valid = 1'b0;
    check("t5_stray_rsp", 512'(bus.rsp_valid), 512'd0);
    check("t5_stray_digest", bus.rsp_digest, 512'd0);
    check("t5_stray_busy", 512'(bus.busy), 512'd0);

    // rr_ptr back to 0; core not ready for 5 cycles in ISSUE.
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    bus.sha_ready = 1'b0;
    tick();
    check("t4_grant0", 512'(bus.grant_id), 512'd0);
    check("t4_busy", 512'(bus.busy), 512'd1);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_ready", 512'(bus.req_ready), 512'd0);
      check("t4_hold_blk", 512'(bus.sha_block_valid), 512'd0);
      tick();
    end
    bus.sha_ready = 1'b1;
    #1;
    check("t4_ready", 512'(bus.req_ready), 512'h1);
    tick();
    check("t4_valid", 512'(bus.sha_block_valid), 512'd1);
    check("t4_first", 512'(bus.sha_first), 512'd1);
    check("t4_blk", bus.sha_block, blk_pat[0]);
    bus.req_valid = 4'b0000;
    bus.sha_digest = pat(32'h4444_0000);
    bus.sha_digest_valid = 1'b1;
    tick();
    bus.sha_digest_valid = 1'b0;
    check("t4_rsp_valid", 512'(bus.rsp_valid), 512'h1);

`ifdef SHA512_ARB_STATS_EN
    do_reset();
    check("t6_blk_reset", 512'(bus.blk_count), 512'd0);
    bus.req_valid = 4'b0001;
    two_block_msg();
    two_block_msg();
    bus.req_valid = 4'b0000;
    tick();
    check("t6_msg0", 512'(bus.msg_count[31:0]), 512'd2);
    check("t6_msg_other", 512'(bus.msg_count[127:32]), 512'd0);
    check("t6_blk", 512'(bus.blk_count), 512'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
